// File: rtl/freq_meter_pkg.sv
// Shared state encoding and constants for the gated-count frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_GATE  = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    localparam int                 DIGIT_W         = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX       = 4'd9;
    localparam int                 SIM_GATE_CYCLES = 50;

endpackage

// File: rtl/bcd_counter.sv
// Cascaded decade counter with synchronous clear and a sticky saturation flag.
// Latency: count/ovf update on the clock edge after clr or inc.
// Backpressure: none; inc is taken every cycle, count holds at all nines.
module bcd_counter
    import freq_meter_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                      clk_50mhz,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      inc,
    output logic [DIGIT_W*DIGITS-1:0] count,
    output logic                      ovf
);

    logic [DIGITS:0]           carry;
    logic [DIGIT_W*DIGITS-1:0] count_nxt;

    // carry[DIGITS] set means the increment would roll past all nines
    always_comb begin
        carry     = '0;
        carry[0]  = inc;
        count_nxt = count;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry[i]) begin
                if (count[i*DIGIT_W +: DIGIT_W] == DIGIT_MAX) begin
                    count_nxt[i*DIGIT_W +: DIGIT_W] = '0;
                    carry[i+1] = 1'b1;
                end else begin
                    count_nxt[i*DIGIT_W +: DIGIT_W] = count[i*DIGIT_W +: DIGIT_W] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (carry[DIGITS]) begin
            ovf   <= 1'b1;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/freq_meter.sv
// Gated-count frequency meter: counts sig_in rising edges per gate window, reports BCD (FREQ_METER_HOLD_EN adds hold).
// Latency: 3 clocks pin-to-count; result published GATE_CYCLES+2 clocks after each window start.
// Backpressure: none; the meter free-runs and valid is a one-cycle strobe with no ready.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50000000,
    parameter int DIGITS      = 8
) (
    input  logic                      clk_50mhz,
    input  logic                      rst,
    input  logic                      sig_in,
`ifdef FREQ_METER_HOLD_EN
    input  logic                      hold,
`endif
    output logic                      gate_o,
    output logic [DIGIT_W*DIGITS-1:0] freq_bcd,
    output logic                      overflow,
    output logic                      valid
);

    localparam int               CNT_W     = $clog2(GATE_CYCLES + 1);
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);

    logic                      sync1, sync2, sync_dly;
    logic                      edge_pulse;
    state_t                    state;
    logic [CNT_W-1:0]          gate_cnt;
    logic                      publish;
    logic                      bcd_clr, bcd_inc;
    logic [DIGIT_W*DIGITS-1:0] bcd_count;
    logic                      bcd_ovf;

    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync_dly <= 1'b0;
        end else begin
            sync1    <= sig_in;
            sync2    <= sync1;
            sync_dly <= sync2;
        end
    end

    assign edge_pulse = sync2 & ~sync_dly;

`ifdef FREQ_METER_HOLD_EN
    assign publish = ~hold;
`else
    assign publish = 1'b1;
`endif

    // Edges outside the gate are dropped rather than carried into the next window
    assign bcd_clr = (state == S_CLEAR);
    assign bcd_inc = edge_pulse & (state == S_GATE);

    bcd_counter #(
        .DIGITS(DIGITS)
    ) u_bcd_counter (
        .clk_50mhz(clk_50mhz),
        .rst      (rst),
        .clr      (bcd_clr),
        .inc      (bcd_inc),
        .count    (bcd_count),
        .ovf      (bcd_ovf)
    );

    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            state    <= S_CLEAR;
            gate_cnt <= '0;
            gate_o   <= 1'b0;
            freq_bcd <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_CLEAR: begin
                    gate_cnt <= '0;
                    gate_o   <= 1'b1;
                    state    <= S_GATE;
                end
                S_GATE: begin
                    if (gate_cnt == GATE_LAST) begin
                        gate_o <= 1'b0;
                        state  <= S_LATCH;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                    end
                end
                S_LATCH: begin
                    if (publish) begin
                        freq_bcd <= bcd_count;
                        overflow <= bcd_ovf;
                        valid    <= 1'b1;
                    end
                    state <= S_CLEAR;
                end
                default: begin
                    gate_o <= 1'b0;
                    state  <= S_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Gated-count frequency meter, the measuring counterpart of the clock divider.
- Counts rising edges of an external signal over a fixed gate window derived from clk_50mhz.
- Reports the count as packed BCD digits, with a one-cycle valid strobe and an overflow flag.
- Sits between the board input pin and the 7-segment display driver.

Parameters:
- GATE_CYCLES, 50000000, clk_50mhz cycles per gate window (1 s gate, so result is in Hz); sims use 50.
- DIGITS, 8, number of BCD digits in the result.

Ports:
- clk_50mhz  input  1  system clock, 50 MHz
- rst  input  1  asynchronous active-low reset
- sig_in  input  1  asynchronous signal under measurement
- gate_o  output  1  high while the gate window is open
- freq_bcd  output  4*DIGITS  latched result, packed BCD, digit 0 in bits [3:0]
- overflow  output  1  result saturated in the last window
- valid  output  1  one-cycle strobe when freq_bcd/overflow update

Behaviour:
- Reset (rst=0, asynchronous):
  - freq_bcd=0, overflow=0, valid=0, gate_o=0.
  - Synchronizer and edge registers=0, gate counter=0, BCD counter=0, state=S_CLEAR.
- Input path: sig_in -> 2-FF synchronizer -> delay FF. An edge is detected when sync2=1 and delay=0. Latency is 3 clocks from pin to edge pulse.
- FSM, free-running:
  - S_CLEAR (1 cycle): clear the BCD counter, its overflow flag and the gate counter -> S_GATE.
  - S_GATE (exactly GATE_CYCLES cycles): gate_o=1; each edge pulse increments the BCD counter; gate counter counts 0..GATE_CYCLES-1 -> S_LATCH.
  - S_LATCH (1 cycle): on the exiting edge, freq_bcd<=BCD count, overflow<=ovf flag, valid<=1 -> S_CLEAR.
- Timing:
  - Measurement period is GATE_CYCLES+2 clocks.
  - valid is high for exactly one cycle per period; freq_bcd and overflow change only on that same edge.
  - First valid goes high GATE_CYCLES+2 rising edges after rst deasserts.
- Edges that occur during S_CLEAR or S_LATCH are dropped, not carried into the next window.
- BCD counter:
  - Cascaded decade digits: each digit wraps 9->0 and carries into the next.
  - When all digits are 9 and an edge arrives, the count holds at all-9s and the sticky ovf flag is set for the rest of the window.
- gate_o is a registered output equal to (state==S_GATE).
- Measurable range: up to 25 MHz (half of clk_50mhz); above that, aliasing is accepted and not flagged.
- Reset mid-window: current count is discarded and outputs return to 0 immediately; a full new window starts after release.

Optional Feature:
- Macro: FREQ_METER_HOLD_EN.
- Defined:
  - Extra input port hold (1 bit, synchronous, active-high).
  - While hold=1, S_LATCH does not update freq_bcd/overflow and valid stays 0; measurement continues.
  - The first S_LATCH with hold=0 publishes normally.
- Undefined: no hold port; every window publishes.

Decomposition:
- Package freq_meter_pkg: state encoding constants S_CLEAR/S_GATE/S_LATCH (2-bit), BCD digit width 4, the digit max value 4'd9, and simulation GATE_CYCLES value 50.
- Sub-module bcd_counter:
  - Function: DIGITS-wide cascaded decade counter with synchronous clr, inc and saturating overflow flag.
  - Ports: clk_50mhz, rst, clr, inc, count[4*DIGITS-1:0], ovf.
  - freq_meter instantiates one.

Test Plan:
- GATE_CYCLES=50, sig_in held 0 -> every valid shows freq_bcd=0x00000000, overflow=0; valid period 52 clocks.
- GATE_CYCLES=50, sig_in period 10 clk (5 high/5 low) -> freq_bcd=0x00000005, overflow=0 on every valid after the first.
- GATE_CYCLES=50, sig_in toggled each clk (period 2) -> freq_bcd=0x00000025; BCD digit carry verified (not 0x19).
- DIGITS=2, GATE_CYCLES=300, sig_in period 2 -> 150 edges -> freq_bcd=0x99, overflow=1. Next window with sig_in=0 -> 0x00, overflow=0.
- Assert rst for 3 clk mid-S_GATE -> outputs 0 asynchronously; first valid exactly 52 clocks after release with the correct count for that window only.
- FREQ_METER_HOLD_EN defined, hold=1 across two windows with sig_in period 10 -> no valid, freq_bcd retains old value. hold=0 -> next valid shows 0x00000005.
